serial_sub_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller. A single 1-bit full-subtractor cell computes a − b − b_in over WIDTH clock cycles, LSB first, with a registered borrow chain.
- Trades area for latency.
- Sits beside the combinational subtractor cells as the sequencer that owns operand shifting, borrow feedback and the start/done handshake.

---
 rtl/serial_sub_ctrl_pkg.sv | 5 +
 rtl/serial_sub_ctrl_fullsub_cell.sv | 11 +
 rtl/serial_sub_ctrl.sv | 81 ++++++++
 tb/tb_serial_sub_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
endpackage

// File: rtl/serial_sub_ctrl_fullsub_cell.sv
// fullsub_cell: combinational 1-bit full subtractor, d = x - y - bi
module fullsub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: LSB-first bit-serial a - b - b_in over WIDTH cycles with start/done handshake
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bor
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, dif_q;
  logic [WIDTH-2:0] r_sh_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, bor_q, d, bo, load, last;
  logic [WIDTH-1:0] res;
  fullsub_cell u_cell (.x(a_sh_q[0]), .y(b_sh_q[0]), .bi(brw_q), .d(d), .bo(bo));
  assign load = start && (state_q != RUN);
  assign last = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  // partial result grows from the top; the final bit completes it
  assign res  = {d, r_sh_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = (state_q == RUN) ? (last ? FIN : RUN) : (start ? RUN : IDLE);
  end
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FIN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      r_sh_q <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      dif_q  <= '0;
      bor_q  <= 1'b0;
    end else if (load) begin
      a_sh_q <= a;
      b_sh_q <= b;
      r_sh_q <= '0;
      brw_q  <= b_in;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      a_sh_q <= a_sh_q >> 1;
      b_sh_q <= b_sh_q >> 1;
      r_sh_q <= res[WIDTH-1:1];
      brw_q  <= bo;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        dif_q <= res;
        bor_q <= bo;
      end
    end
  assign dif = dif_q;
  assign bor = bor_q;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  // brw_q on the last step is the borrow into the MSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (last) ovf_q <= brw_q ^ bo;
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: self-checking bench for serial_sub_ctrl against an arithmetic reference
module tb_serial_sub_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       b_in = 1'b0;
  logic       busy, done, bor;
  logic [7:0] dif;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif
  int checks = 0;
  int fails = 0;
  logic [7:0] last_dif = '0;
  logic last_bor = 1'b0, last_ovf = 1'b0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .dif(dif), .bor(bor)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got busy=%b want finished", busy);
    $fatal(1, "timeout");
  end

  // returns {ovf, bor, dif}
  function automatic logic [9:0] ref_sub(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int u, s;
    logic [7:0] r;
    u = int'(av) - int'(bv) - int'(bi);
    s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    r = u[7:0];
    return {(s < -128) || (s > 127), u < 0, r};
  endfunction

  task automatic check_result(input logic [9:0] e, input string nm);
    checks++;
    if (dif !== e[7:0] || bor !== e[8]) begin
      fails++;
      $display("FAIL %s: got dif=%h bor=%b want dif=%h bor=%b", nm, dif, bor, e[7:0], e[8]);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== e[9]) begin
      fails++;
      $display("FAIL %s_ovf: got ovf=%b want %b", nm, ovf, e[9]);
    end
`endif
    last_dif = e[7:0];
    last_bor = e[8];
    last_ovf = e[9];
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi, input bit noise, input string nm);
    logic [9:0] e;
    e = ref_sub(av, bv, bi);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; b_in = bi;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== (k < 8)) begin
        fails++;
        $display("FAIL %s_busy k=%0d: got %b want %b", nm, k, busy, k < 8);
      end
      checks++;
      if (done !== (k == 8)) begin
        fails++;
        $display("FAIL %s_done k=%0d: got %b want %b", nm, k, done, k == 8);
      end
      if (k < 8) begin
        checks++;
        if (dif !== last_dif || bor !== last_bor) begin
          fails++;
          $display("FAIL %s_stable k=%0d: got dif=%h bor=%b want dif=%h bor=%b", nm, k, dif, bor, last_dif, last_bor);
        end
      end
      start = (noise && k < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
      end
    end
    check_result(e, nm);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: got busy=%b done=%b want 0 0", nm, busy, done);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dif !== 8'h00 || bor !== 1'b0) begin
      fails++;
      $display("FAIL reset: got busy=%b done=%b dif=%h bor=%b want 0 0 00 0", busy, done, dif, bor);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    do_op(8'h5A, 8'h23, 1'b0, 1'b0, "d_5a_23");
    do_op(8'h00, 8'h01, 1'b0, 1'b0, "d_00_01");
    do_op(8'h10, 8'h10, 1'b1, 1'b0, "d_10_10_bi");
    do_op(8'h80, 8'h01, 1'b0, 1'b0, "d_80_01");
    do_op(8'hFF, 8'h00, 1'b0, 1'b0, "d_ff_00");
    do_op(8'h00, 8'hFF, 1'b1, 1'b0, "d_00_ff_bi");
    do_op(8'h7F, 8'h80, 1'b0, 1'b0, "d_7f_80");
  endtask

  task automatic test_ignore_start;
    do_op(8'hC3, 8'h5E, 1'b1, 1'b1, "ign_c3_5e");
    do_op(8'h12, 8'h34, 1'b0, 1'b1, "ign_12_34");
  endtask

  task automatic test_back_to_back;
    logic [9:0] e1, e2;
    int d1, d2;
    e1 = ref_sub(8'h9C, 8'h27, 1'b0);
    e2 = ref_sub(8'h31, 8'hA5, 1'b1);
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    start = 1'b1; a = 8'h9C; b = 8'h27; b_in = 1'b0;
    @(negedge clk);
    a = 8'h31; b = 8'hA5; b_in = 1'b1;
    for (int c = 0; c < 30 && d2 < 0; c++) begin
      if (d1 >= 0 && c == d1 + 1) begin
        checks++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_no_idle: got busy=%b want 1", busy);
        end
        start = 1'b0;
      end
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = c;
          check_result(e1, "b2b_first");
        end else begin
          d2 = c;
          check_result(e2, "b2b_second");
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (d1 != 8 || d2 - d1 != 9) begin
      fails++;
      $display("FAIL b2b_spacing: got first=%0d gap=%0d want first=8 gap=9", d1, d2 - d1);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    bit seen;
    do_op(8'hA7, 8'h3C, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1; a = 8'h44; b = 8'h11; b_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dif !== 8'h00 || bor !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: got busy=%b done=%b dif=%h bor=%b want 0 0 00 0", busy, done, dif, bor);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL abort_ovf: got %b want 0", ovf);
    end
`endif
    last_dif = '0;
    last_bor = 1'b0;
    last_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL abort_no_done: got activity=1 want 0");
    end
    do_op(8'h44, 8'h11, 1'b0, 1'b0, "post_abort");
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "rand");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
